uart_ctl_rx: RTL
================

// Module: uart_ctl_rx
// PURPOSE
//  UART receiver and command decoder that drives the picture-frame controller's ctl_* port.
//  Receives 8N1 bytes on uart_rx and decodes next/previous picture commands.
//  Presents each command on a four-phase valid/ready handshake toward the frame controller.
//  Sits between the board UART RX pin and the frame controller, in the clk_4M domain.
// PARAMETERS
//  CLKS_PER_BIT  417  clk_4M cycles per UART bit (4 MHz / 9600 baud); legal range >= 8.
//  HALF_BIT      CLKS_PER_BIT/2  start-bit mid-sample point, in cycles.
// PORTS
//  clk_4M        in   1  system clock. Single clock domain.
//  rst_n         in   1  reset: synchronous, active-low.
//  uart_rx       in   1  asynchronous serial input; idle high.
//  ctl_incr      out  1  next-picture command; valid only while ctl_valid=1.
//  ctl_decr      out  1  previous-picture command; valid only while ctl_valid=1.
//  ctl_valid     out  1  command pending; exactly one of incr/decr is high while it is asserted.
//  ctl_ready     in   1  acknowledge from the frame controller.
//  rx_frame_err  out  1  one-cycle pulse: stop bit sampled 0.
//  rx_overrun    out  1  one-cycle pulse: valid command dropped because a handshake was busy.
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; bit/clock counters 0; 2-FF uart_rx synchroniser loads 1.
//   Reset mid-byte or mid-handshake discards everything; no partial command survives.
//  The RX FSM uses the synchronised input rxs, so pin-to-FSM latency is 2 cycles.
//  RX FSM, encoded in 3 bits:
//   IDLE: clk_cnt=0; when rxs==0, go to START.
//   START: count to HALF_BIT-1, then sample. rxs==1 is a glitch: go to IDLE. rxs==0: clk_cnt=0, bit_cnt=0, go to DATA.
//   DATA: on every clk_cnt==CLKS_PER_BIT-1, shift rxs in LSB-first and clear clk_cnt. After the 8th bit, go to STOP.
//   STOP: at CLKS_PER_BIT-1, sample.
//    rxs==1: byte is good; run the decode; go to IDLE.
//    rxs==0: pulse rx_frame_err; go to BREAK.
//   BREAK: stay until rxs==1, then go to IDLE. A line held low must not yield repeated errors.
//  Decode of a good byte:
//   0x2B '+' or 0x6E 'n' is INCR.
//   0x2D '-' or 0x70 'p' is DECR.
//   Any other byte is silently ignored: no pulse.
//  Handshake states: H_IDLE, H_VALID, H_WAIT_LOW.
//   H_IDLE + decoded cmd: next cycle ctl_valid=1 with the matching incr/decr bit; go to H_VALID.
//    Latency is 1 cycle from the stop-bit sample edge.
//   H_VALID: hold valid, incr and decr stable. When ctl_ready==1 is sampled, clear all three next cycle and go to H_WAIT_LOW.
//   H_WAIT_LOW: go to H_IDLE once ctl_ready==0 is sampled. valid is never re-asserted while ready is high.
//   A decoded cmd in H_VALID or H_WAIT_LOW is dropped and pulses rx_overrun; the pending cmd is unchanged.
//   Decode and ready in the same cycle while in H_VALID: the ack wins, and the new cmd counts as an overrun.
//  ctl_ready high while in H_IDLE is ignored.
//  Counter widths are $clog2(CLKS_PER_BIT) for clock counts and 3 bits for bit_cnt; no wrap occurs inside a byte.
//  Reception continues during the handshake, and the RX FSM never stalls.
// TESTING
//  1 Send 0x2B at CLKS_PER_BIT=417 with ready low.
//    -> ctl_valid=1 and ctl_incr=1, ctl_decr=0, 1 cycle after the stop-bit mid-sample. Held for 1000 cycles.
//  2 From case 1, raise ctl_ready for 3 cycles.
//    -> valid/incr drop 1 cycle after ready is first sampled high.
//    -> A '-' received while ready is still high pulses rx_overrun, and valid stays 0.
//  3 Send 0x2D, ack it, drop ready, then send 0x70.
//    -> two separate DECR handshakes; rx_overrun never pulses.
//  4 Drive a 150-cycle low glitch on uart_rx, then send 0x41.
//    -> no valid, no rx_frame_err, FSM back in IDLE.
//  5 Send 0x2B with a stop bit of 0, then hold uart_rx low for 5000 cycles.
//    -> exactly one rx_frame_err pulse and no valid.
//    -> After release, a following '+' is decoded normally.
//  6 Assert rst_n=0 for 1 cycle in the middle of DATA bit 4, then send 'n'.
//    -> all outputs 0 during reset; the partial byte is discarded; the next 'n' gives INCR.

Source files
------------

// File: rtl/uart_ctl_rx.sv
// uart_ctl_rx: UART 8N1 receiver and command decoder for the picture-frame
// controller. Decoded next/previous-picture bytes are presented on a
// four-phase valid/ready handshake. Single clock domain (clk_4M).
//
// Ports:
//   clk_4M        in   system clock
//   rst_n         in   synchronous active-low reset
//   uart_rx       in   asynchronous serial input, idle high
//   ctl_incr      out  next-picture command (qualified by ctl_valid)
//   ctl_decr      out  previous-picture command (qualified by ctl_valid)
//   ctl_valid     out  command pending
//   ctl_ready     in   acknowledge from the frame controller
//   rx_frame_err  out  one-cycle pulse: stop bit sampled low
//   rx_overrun    out  one-cycle pulse: decoded command dropped, handshake busy
module uart_ctl_rx #(
  parameter int CLKS_PER_BIT = 417,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic clk_4M,
  input  logic rst_n,
  input  logic uart_rx,
  output logic ctl_incr,
  output logic ctl_decr,
  output logic ctl_valid,
  input  logic ctl_ready,
  output logic rx_frame_err,
  output logic rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_C = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    H_IDLE     = 2'd0,
    H_VALID    = 2'd1,
    H_WAIT_LOW = 2'd2
  } hs_state_t;

  // Byte decode: returns {incr, decr}; unknown bytes give 2'b00.
  function automatic logic [1:0] decode_byte(input logic [7:0] b);
    logic [1:0] r;
    case (b)
      8'h2B, 8'h6E: r = 2'b10;
      8'h2D, 8'h70: r = 2'b01;
      default:      r = 2'b00;
    endcase
    return r;
  endfunction

  logic            rx_meta_r, rxs_r;
  rx_state_t       rx_state_r, rx_state_s;
  logic [CW-1:0]   clk_cnt_r, clk_cnt_s;
  logic [2:0]      bit_cnt_r, bit_cnt_s;
  logic [7:0]      shift_r, shift_s;
  logic            byte_good_s, frame_err_s;
  logic [1:0]      cmd_s;
  logic            cmd_any_s;
  hs_state_t       hs_state_r, hs_state_s;
  logic            valid_r, valid_s, incr_r, incr_s, decr_r, decr_s;
  logic            ferr_r, ovr_r, ovr_s;

  // RX bit-level FSM: next state, counters and shift register.
  always_comb begin
    rx_state_s  = rx_state_r;
    clk_cnt_s   = clk_cnt_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    byte_good_s = 1'b0;
    frame_err_s = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        clk_cnt_s = ZERO_C;
        if (!rxs_r) rx_state_s = RX_START;
        else        rx_state_s = RX_IDLE;
      end
      RX_START: begin
        if (clk_cnt_r == HALF_C) begin
          // Mid start bit: a high line means the falling edge was a glitch.
          clk_cnt_s = ZERO_C;
          bit_cnt_s = 3'd0;
          if (rxs_r) rx_state_s = RX_IDLE;
          else       rx_state_s = RX_DATA;
        end else begin
          clk_cnt_s = clk_cnt_r + ONE_C;
        end
      end
      RX_DATA: begin
        if (clk_cnt_r == LAST_C) begin
          clk_cnt_s = ZERO_C;
          shift_s   = {rxs_r, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) rx_state_s = RX_STOP;
          else                   rx_state_s = RX_DATA;
        end else begin
          clk_cnt_s = clk_cnt_r + ONE_C;
        end
      end
      RX_STOP: begin
        if (clk_cnt_r == LAST_C) begin
          clk_cnt_s = ZERO_C;
          if (rxs_r) begin
            byte_good_s = 1'b1;
            rx_state_s  = RX_IDLE;
          end else begin
            frame_err_s = 1'b1;
            rx_state_s  = RX_BREAK;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + ONE_C;
        end
      end
      RX_BREAK: begin
        // Wait out a held-low line so it reports only one framing error.
        clk_cnt_s = ZERO_C;
        if (rxs_r) rx_state_s = RX_IDLE;
        else       rx_state_s = RX_BREAK;
      end
      default: begin
        rx_state_s = RX_IDLE;
        clk_cnt_s  = ZERO_C;
      end
    endcase
  end

  assign cmd_s     = byte_good_s ? decode_byte(shift_r) : 2'b00;
  assign cmd_any_s = |cmd_s;

  // Handshake FSM: presents a command, waits for ack, then ready low.
  always_comb begin
    hs_state_s = hs_state_r;
    valid_s    = valid_r;
    incr_s     = incr_r;
    decr_s     = decr_r;
    ovr_s      = 1'b0;
    case (hs_state_r)
      H_IDLE: begin
        if (cmd_any_s) begin
          valid_s    = 1'b1;
          incr_s     = cmd_s[1];
          decr_s     = cmd_s[0];
          hs_state_s = H_VALID;
        end else begin
          hs_state_s = H_IDLE;
        end
      end
      H_VALID: begin
        // A command arriving together with the ack is still an overrun.
        ovr_s = cmd_any_s;
        if (ctl_ready) begin
          valid_s    = 1'b0;
          incr_s     = 1'b0;
          decr_s     = 1'b0;
          hs_state_s = H_WAIT_LOW;
        end else begin
          hs_state_s = H_VALID;
        end
      end
      H_WAIT_LOW: begin
        ovr_s = cmd_any_s;
        if (!ctl_ready) hs_state_s = H_IDLE;
        else            hs_state_s = H_WAIT_LOW;
      end
      default: begin
        hs_state_s = H_IDLE;
        valid_s    = 1'b0;
        incr_s     = 1'b0;
        decr_s     = 1'b0;
      end
    endcase
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk_4M) begin
    if (!rst_n) begin
      rx_meta_r  <= 1'b1;
      rxs_r      <= 1'b1;
      rx_state_r <= RX_IDLE;
      clk_cnt_r  <= ZERO_C;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      hs_state_r <= H_IDLE;
      valid_r    <= 1'b0;
      incr_r     <= 1'b0;
      decr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      ovr_r      <= 1'b0;
    end else begin
      rx_meta_r  <= uart_rx;
      rxs_r      <= rx_meta_r;
      rx_state_r <= rx_state_s;
      clk_cnt_r  <= clk_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      hs_state_r <= hs_state_s;
      valid_r    <= valid_s;
      incr_r     <= incr_s;
      decr_r     <= decr_s;
      ferr_r     <= frame_err_s;
      ovr_r      <= ovr_s;
    end
  end

  assign ctl_valid    = valid_r;
  assign ctl_incr     = incr_r;
  assign ctl_decr     = decr_r;
  assign rx_frame_err = ferr_r;
  assign rx_overrun   = ovr_r;

endmodule
